// File: rtl/ic_rsp_router_pkg.sv
// Shared interconnect definitions: route tag encoding, error response data and a route encoder.
package ic_rsp_router_pkg;

  typedef logic [1:0] ic_tag_t;

  localparam ic_tag_t IC_ROUTE_ROM = 2'd0;
  localparam ic_tag_t IC_ROUTE_RAM = 2'd1;
  localparam ic_tag_t IC_ROUTE_AXI = 2'd2;
  localparam ic_tag_t IC_ROUTE_ERR = 2'd3;

  localparam logic [31:0] IC_ERR_RDATA = 32'h0;

  // Anything other than exactly one target (with no decode error) routes to ERR.
  function automatic ic_tag_t ic_encode_route(input logic rom, input logic ram,
                                              input logic axi, input logic dec_err);
    ic_tag_t tag;
    case ({dec_err, axi, ram, rom})
      4'b0001: tag = IC_ROUTE_ROM;
      4'b0010: tag = IC_ROUTE_RAM;
      4'b0100: tag = IC_ROUTE_AXI;
      default: tag = IC_ROUTE_ERR;
    endcase
    return tag;
  endfunction

endpackage

// File: rtl/ic_rsp_router_tag_fifo.sv
// ic_tag_fifo: generic synchronous FIFO with combinational head; push ignored when full,
// pop ignored when empty.
module ic_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ic_rsp_router.sv
// Returns target responses to the initiator in request order and synthesises decode-error
// responses. Optional error counter enabled by IC_RSP_ROUTER_ERR_COUNT_EN.
module ic_rsp_router
  import ic_rsp_router_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        req_fire,
  input  logic        route_rom,
  input  logic        route_ram,
  input  logic        route_axi,
  input  logic        req_dec_err,
  output logic        tag_full,
  input  logic        rom_rsp_valid,
  output logic        rom_rsp_ready,
  input  logic [31:0] rom_rsp_rdata,
  input  logic        rom_rsp_error,
  input  logic        ram_rsp_valid,
  output logic        ram_rsp_ready,
  input  logic [31:0] ram_rsp_rdata,
  input  logic        ram_rsp_error,
  input  logic        axi_rsp_valid,
  output logic        axi_rsp_ready,
  input  logic [31:0] axi_rsp_rdata,
  input  logic        axi_rsp_error,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [15:0] err_count
);

  ic_tag_t push_tag;
  ic_tag_t head_tag;
  logic    fifo_empty;
  logic    rsp_pop;

  assign push_tag = ic_encode_route(route_rom, route_ram, route_axi, req_dec_err);
  assign rsp_pop  = rsp_valid && rsp_ready;

  ic_tag_fifo #(
    .WIDTH(2),
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .push    (req_fire),
    .wdata   (push_tag),
    .pop     (rsp_pop),
    .head    (head_tag),
    .full    (tag_full),
    .empty   (fifo_empty)
  );

  // Only the head target sees rsp_ready; later targets are held off until their turn.
  always_comb begin
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    rsp_error     = 1'b0;
    rom_rsp_ready = 1'b0;
    ram_rsp_ready = 1'b0;
    axi_rsp_ready = 1'b0;
    if (!fifo_empty) begin
      unique case (head_tag)
        IC_ROUTE_ROM: begin
          rsp_valid     = rom_rsp_valid;
          rsp_rdata     = rom_rsp_rdata;
          rsp_error     = rom_rsp_error;
          rom_rsp_ready = rsp_ready;
        end
        IC_ROUTE_RAM: begin
          rsp_valid     = ram_rsp_valid;
          rsp_rdata     = ram_rsp_rdata;
          rsp_error     = ram_rsp_error;
          ram_rsp_ready = rsp_ready;
        end
        IC_ROUTE_AXI: begin
          rsp_valid     = axi_rsp_valid;
          rsp_rdata     = axi_rsp_rdata;
          rsp_error     = axi_rsp_error;
          axi_rsp_ready = rsp_ready;
        end
        IC_ROUTE_ERR: begin
          rsp_valid = 1'b1;
          rsp_rdata = IC_ERR_RDATA;
          rsp_error = 1'b1;
        end
      endcase
    end
  end

`ifdef IC_RSP_ROUTER_ERR_COUNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      err_count_q <= '0;
    end else if (rsp_pop && rsp_error && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'h0;
`endif

endmodule

// File: tb/tb_ic_rsp_router.sv
// Scoreboard bench for ic_rsp_router: expected responses are queued as stimulus is driven and
// compared on every initiator handshake.
module tb_ic_rsp_router;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        req_fire, route_rom, route_ram, route_axi, req_dec_err;
  logic        tag_full;
  logic        rom_rsp_valid, rom_rsp_ready, rom_rsp_error;
  logic        ram_rsp_valid, ram_rsp_ready, ram_rsp_error;
  logic        axi_rsp_valid, axi_rsp_ready, axi_rsp_error;
  logic [31:0] rom_rsp_rdata, ram_rsp_rdata, axi_rsp_rdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [15:0] err_count;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   delivered  = 0;

`ifdef IC_RSP_ROUTER_ERR_COUNT_EN
  localparam logic [31:0] ErrCntAfterOne = 32'd1;
`else
  localparam logic [31:0] ErrCntAfterOne = 32'd0;
`endif

  ic_rsp_router #(.DEPTH(4)) dut (
    .g_clk        (g_clk),
    .g_resetn     (g_resetn),
    .req_fire     (req_fire),
    .route_rom    (route_rom),
    .route_ram    (route_ram),
    .route_axi    (route_axi),
    .req_dec_err  (req_dec_err),
    .tag_full     (tag_full),
    .rom_rsp_valid(rom_rsp_valid),
    .rom_rsp_ready(rom_rsp_ready),
    .rom_rsp_rdata(rom_rsp_rdata),
    .rom_rsp_error(rom_rsp_error),
    .ram_rsp_valid(ram_rsp_valid),
    .ram_rsp_ready(ram_rsp_ready),
    .ram_rsp_rdata(ram_rsp_rdata),
    .ram_rsp_error(ram_rsp_error),
    .axi_rsp_valid(axi_rsp_valid),
    .axi_rsp_ready(axi_rsp_ready),
    .axi_rsp_rdata(axi_rsp_rdata),
    .axi_rsp_error(axi_rsp_error),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .err_count    (err_count)
  );

  always #5 g_clk = ~g_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled on the falling edge, away from input changes and the active edge.
  always @(negedge g_clk) begin
    if (g_resetn === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      delivered++;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_rdata", rsp_rdata, e.rdata);
        check_eq("sb_error", {31'd0, rsp_error}, {31'd0, e.err});
      end
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic expect_rsp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  task automatic fire(input logic rom, input logic ram, input logic axi, input logic dec);
    req_fire    = 1'b1;
    route_rom   = rom;
    route_ram   = ram;
    route_axi   = axi;
    req_dec_err = dec;
    tick();
    req_fire    = 1'b0;
    route_rom   = 1'b0;
    route_ram   = 1'b0;
    route_axi   = 1'b0;
    req_dec_err = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check_eq(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    g_resetn    = 1'b0;
    req_fire    = 1'b0;
    route_rom   = 1'b0;
    route_ram   = 1'b0;
    route_axi   = 1'b0;
    req_dec_err = 1'b0;
    rsp_ready   = 1'b0;
    {rom_rsp_valid, rom_rsp_error, rom_rsp_rdata} = '0;
    {ram_rsp_valid, ram_rsp_error, ram_rsp_rdata} = '0;
    {axi_rsp_valid, axi_rsp_error, axi_rsp_rdata} = '0;
    tick();
    tick();
    g_resetn = 1'b1;

    check_eq("rst_tag_full", {31'd0, tag_full}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_error", {31'd0, rsp_error}, 32'd0);
    check_eq("rst_readies", {29'd0, rom_rsp_ready, ram_rsp_ready, axi_rsp_ready}, 32'd0);
    check_eq("rst_err_count", {16'd0, err_count}, 32'd0);

    // Single RAM read
    rsp_ready = 1'b1;
    fire(1'b0, 1'b1, 1'b0, 1'b0);
    ram_rsp_valid = 1'b1;
    ram_rsp_rdata = 32'hDEADBEEF;
    expect_rsp(32'hDEADBEEF, 1'b0);
    #1;
    check_eq("ram_ready", {31'd0, ram_rsp_ready}, 32'd1);
    check_eq("ram_other_ready", {30'd0, rom_rsp_ready, axi_rsp_ready}, 32'd0);
    tick();
    ram_rsp_valid = 1'b0;
    wait_drain("ram_drain");
    check_eq("ram_empty_after", {31'd0, rsp_valid}, 32'd0);

    // Decode error, synthesised response with no target involvement
    fire(1'b0, 1'b0, 1'b0, 1'b1);
    expect_rsp(32'h0, 1'b1);
    check_eq("dec_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("dec_error", {31'd0, rsp_error}, 32'd1);
    check_eq("dec_readies", {29'd0, rom_rsp_ready, ram_rsp_ready, axi_rsp_ready}, 32'd0);
    tick();
    wait_drain("dec_drain");
    check_eq("dec_empty_after", {31'd0, rsp_valid}, 32'd0);
    check_eq("dec_err_count", {16'd0, err_count}, ErrCntAfterOne);

    // Ordering: AXI answers early but must wait behind ROM
    fire(1'b1, 1'b0, 1'b0, 1'b0);
    fire(1'b0, 1'b0, 1'b1, 1'b0);
    axi_rsp_valid = 1'b1;
    axi_rsp_rdata = 32'h2;
    #1;
    check_eq("ord_axi_blocked0", {31'd0, axi_rsp_ready}, 32'd0);
    check_eq("ord_no_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_eq("ord_axi_blocked1", {31'd0, axi_rsp_ready}, 32'd0);
    tick();
    rom_rsp_valid = 1'b1;
    rom_rsp_rdata = 32'h1;
    expect_rsp(32'h1, 1'b0);
    #1;
    check_eq("ord_rom_ready", {31'd0, rom_rsp_ready}, 32'd1);
    check_eq("ord_axi_blocked2", {31'd0, axi_rsp_ready}, 32'd0);
    tick();
    rom_rsp_valid = 1'b0;
    expect_rsp(32'h2, 1'b0);
    #1;
    check_eq("ord_axi_ready", {31'd0, axi_rsp_ready}, 32'd1);
    tick();
    axi_rsp_valid = 1'b0;
    wait_drain("ord_drain");

    // Full and back-pressure; a fifth fire while full must be dropped
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) fire(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("full_set", {31'd0, tag_full}, 32'd1);
    fire(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("full_still", {31'd0, tag_full}, 32'd1);
    delivered     = 0;
    rsp_ready     = 1'b1;
    ram_rsp_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ram_rsp_rdata = 32'h100 + k;
      if (k < 4) expect_rsp(32'h100 + k, 1'b0);
      #1;
      check_eq($sformatf("full_flag_%0d", k), {31'd0, tag_full}, (k == 0) ? 32'd1 : 32'd0);
      tick();
    end
    ram_rsp_valid = 1'b0;
    check_eq("full_delivered", delivered, 32'd4);
    wait_drain("full_drain");

    // Steady push+pop at count 2 across pointer wrap
    rsp_ready = 1'b0;
    fire(1'b0, 1'b1, 1'b0, 1'b0);
    fire(1'b0, 1'b1, 1'b0, 1'b0);
    rsp_ready     = 1'b1;
    ram_rsp_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req_fire      = (k < 8);
      route_ram     = (k < 8);
      ram_rsp_rdata = 32'h200 + k;
      expect_rsp(32'h200 + k, 1'b0);
      #1;
      check_eq($sformatf("pp_valid_%0d", k), {31'd0, rsp_valid}, 32'd1);
      check_eq($sformatf("pp_not_full_%0d", k), {31'd0, tag_full}, 32'd0);
      tick();
    end
    req_fire      = 1'b0;
    route_ram     = 1'b0;
    ram_rsp_valid = 1'b0;
    #1;
    check_eq("pp_empty_after", {31'd0, rsp_valid}, 32'd0);
    wait_drain("pp_drain");

    // Reset mid-flight, then a non-one-hot route
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) fire(1'b1, 1'b0, 1'b0, 1'b0);
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    check_eq("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("mid_rst_full", {31'd0, tag_full}, 32'd0);
    check_eq("mid_rst_err_count", {16'd0, err_count}, 32'd0);
    rom_rsp_valid = 1'b1;
    #1;
    check_eq("mid_rst_rom_ignored", {31'd0, rsp_valid}, 32'd0);
    rom_rsp_valid = 1'b0;
    rsp_ready     = 1'b1;
    fire(1'b1, 1'b1, 1'b0, 1'b0);
    expect_rsp(32'h0, 1'b1);
    check_eq("bad_route_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("bad_route_error", {31'd0, rsp_error}, 32'd1);
    tick();
    wait_drain("bad_route_drain");
    check_eq("bad_route_err_count", {16'd0, err_count}, ErrCntAfterOne);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ic_rsp_router.md
Name: ic_rsp_router

Overview:
- Response-return half of the interconnect. The address decoder steers each request forward to ROM, RAM or AXI, or flags it as a decode error; this block carries each response back to the single initiator.
- Records the route of every accepted request in an in-order tag FIFO.
- Forwards responses only from the target at the FIFO head.
- Synthesises error responses for requests that matched no target.
- Sits between the three target response channels and the CPU response port.

Parameters:
- DEPTH, 4, maximum outstanding requests; power of two, 2 to 16.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous active-low reset
- req_fire  in  1  initiator request handshake completed this cycle
- route_rom  in  1  fired request routed to ROM (from decoder)
- route_ram  in  1  fired request routed to RAM
- route_axi  in  1  fired request routed to AXI bridge
- req_dec_err  in  1  fired request matched no target
- tag_full  out  1  FIFO holds DEPTH entries; initiator must not fire
- rom_rsp_valid / rom_rsp_ready / rom_rsp_rdata / rom_rsp_error  in/out/in/in  1/1/32/1  ROM response channel
- ram_rsp_valid / ram_rsp_ready / ram_rsp_rdata / ram_rsp_error  in/out/in/in  1/1/32/1  RAM response channel
- axi_rsp_valid / axi_rsp_ready / axi_rsp_rdata / axi_rsp_error  in/out/in/in  1/1/32/1  AXI response channel
- rsp_valid  out  1  response to initiator valid
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  response read data
- rsp_error  out  1  bus error
- err_count  out  16  saturating count of error responses delivered (see Optional Feature)

Behaviour:
- Clock and reset: clock g_clk; reset g_resetn, synchronous, active-low.
  - On reset: wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: tag_full=0, rsp_valid=0, all *_rsp_ready=0, rsp_rdata=0, rsp_error=0, err_count=0.
  - Reset mid-operation discards all outstanding tags. Any responses still in flight from targets are the targets' concern; the targets are reset by the same g_resetn.
- Tag encoding (2 bits): ROM=0, RAM=1, AXI=2, ERR=3.
  - On req_fire, push the encoded route.
  - Route inputs not exactly one-hot (zero asserted, or two or more asserted) push ERR.
- Push condition: req_fire && !tag_full.
  - req_fire while tag_full is a protocol violation. The tag is dropped and state is unchanged.
- Head decode: combinational from fifo[rd_ptr] when count!=0. Zero-latency response path.
  - Head ROM/RAM/AXI: rsp_valid, rsp_rdata and rsp_error mirror that target's channel. That target's *_rsp_ready = rsp_ready. Other targets' ready = 0, so out-of-order responses are back-pressured.
  - Head ERR: rsp_valid=1, rsp_error=1, rsp_rdata=32'h0, independent of all target channels. All target ready = 0.
  - Empty (count==0): rsp_valid=0, rsp_rdata=0, rsp_error=0, all target ready = 0.
- Pop condition: rsp_valid && rsp_ready. rd_ptr increments and wraps modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - Legal when full: tag_full is evaluated on the registered count, so no push occurs when full even if a pop happens that cycle.
  - Push into an empty FIFO: the entry becomes head on the next cycle. Minimum request-to-response turnaround is one cycle.
- tag_full = (count == DEPTH), registered-state derived. count is PTR_W+1 bits.
- Pointer wrap: wr_ptr and rd_ptr wrap from DEPTH-1 to 0.

Optional Feature:
- Macro: IC_RSP_ROUTER_ERR_COUNT_EN.
- Defined:
  - err_count increments by 1 on every pop with rsp_error=1, covering both target errors and synthesised ERR.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: err_count tied to 16'h0 and the counter logic is absent.

Decomposition:
- Shared interconnect package holds:
  - Route tag localparams: IC_ROUTE_ROM=2'd0, IC_ROUTE_RAM=2'd1, IC_ROUTE_AXI=2'd2, IC_ROUTE_ERR=2'd3.
  - Error response data constant 32'h0.
- One sub-module, ic_tag_fifo: generic synchronous FIFO, width 2, depth DEPTH, with push/pop/full/empty/head ports.
- Head mux and error-response generation stay in ic_rsp_router.

Test Plan:
- Single RAM read: fire route_ram; RAM returns valid with rdata=32'hDEADBEEF one cycle later, rsp_ready=1 -> rsp_valid=1, rsp_rdata=32'hDEADBEEF, rsp_error=0; count returns to 0.
- Decode error: fire req_dec_err, rsp_ready=1 -> next cycle rsp_valid=1, rsp_error=1, rsp_rdata=0; no target sees ready.
- Ordering: fire ROM then AXI; AXI responds first with 32'h2, ROM two cycles later with 32'h1 -> axi_rsp_ready held 0 until ROM delivered; initiator sees 32'h1 then 32'h2.
- Full and back-pressure: DEPTH=4, fire 4 RAM requests, rsp_ready=0 -> tag_full=1. A 5th fire is ignored. Drain 4 responses -> exactly 4 delivered, tag_full falls after the first pop.
- Simultaneous push/pop at count=2 over 8 cycles -> count stays 2; pointers wrap past index 3 correctly.
- Reset mid-flight with 3 outstanding, and a non-one-hot route (rom+ram) fired after reset -> after reset count=0 and rsp_valid=0; the bad route yields an error response. With IC_RSP_ROUTER_ERR_COUNT_EN, err_count=1.
